// File: rtl/sync_stream_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : sync_stream_fifo
//  Brief   : Single-clock FWFT FIFO with backpressure, level, almost-full,
//            sticky overflow and an optional empty-FIFO bypass path.
//  Rev     : 1.0
// ============================================================================
module sync_stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter bit LOW_LAT    = 1'b1,
    parameter int AF_THRESH  = DEPTH - 2
) (
    input  logic                       clkIn,
    input  logic                       rstIn,
    input  logic                       wrEnIn,
    input  logic [DATA_WIDTH-1:0]      wrDataIn,
    output logic                       wrFullOut,
    output logic                       wrAlmostFullOut,
    input  logic                       rdReadyIn,
    output logic [DATA_WIDTH-1:0]      rdDataOut,
    output logic                       rdDataValidOut,
    output logic [$clog2(DEPTH):0]     levelOut,
    output logic                       overflowOut,
    input  logic                       overflowClrIn
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] c_DEPTH = LW'(DEPTH);
    localparam logic [LW-1:0] c_AF    = LW'(AF_THRESH);
    localparam logic [LW-1:0] c_ONE   = LW'(1);
    localparam logic [LW-1:0] c_ZERO  = '0;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wrPtr;
    logic [AW-1:0]         r_rdPtr;
    logic [LW-1:0]         r_ramCount;
    logic [LW-1:0]         r_level;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ovf;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;
    logic                  w_load;
    logic                  w_fromRam;
    logic                  w_bypass;
    logic                  w_ramWr;
    logic [LW-1:0]         w_levelNext;
    logic [LW-1:0]         w_ramCountNext;

    // Acceptance depends only on the registered full flag, so a same-cycle pop
    // never rescues a write presented while full.
    assign w_push    = wrEnIn & ~r_full;
    assign w_drop    = wrEnIn &  r_full;
    assign w_pop     = r_valid & rdReadyIn;
    assign w_load    = ~r_valid | w_pop;
    assign w_fromRam = w_load & (r_ramCount != c_ZERO);
    assign w_bypass  = LOW_LAT & w_load & (r_ramCount == c_ZERO) & w_push;
    assign w_ramWr   = w_push & ~w_bypass;

    always_comb begin
        w_levelNext = r_level;
        case ({w_push, w_pop})
            2'b10:   w_levelNext = r_level + c_ONE;
            2'b01:   w_levelNext = r_level - c_ONE;
            default: w_levelNext = r_level;
        endcase
    end

    always_comb begin
        w_ramCountNext = r_ramCount;
        case ({w_ramWr, w_fromRam})
            2'b10:   w_ramCountNext = r_ramCount + c_ONE;
            2'b01:   w_ramCountNext = r_ramCount - c_ONE;
            default: w_ramCountNext = r_ramCount;
        endcase
    end

    // Storage array carries no reset so it can map onto RAM primitives.
    always_ff @(posedge clkIn) begin
        if (w_ramWr) begin
            r_mem[r_wrPtr] <= wrDataIn;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_ramCount <= '0;
            r_level    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_ramWr) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_fromRam) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                r_data  <= r_mem[r_rdPtr];
            end else if (w_bypass) begin
                r_data  <= wrDataIn;
            end
            if (w_load) begin
                r_valid <= w_fromRam | w_bypass;
            end
            r_ramCount <= w_ramCountNext;
            r_level    <= w_levelNext;
            r_full     <= (w_levelNext == c_DEPTH);
            r_af       <= (w_levelNext >= c_AF);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (overflowClrIn) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign wrFullOut       = r_full;
    assign wrAlmostFullOut = r_af;
    assign rdDataOut       = r_data;
    assign rdDataValidOut  = r_valid;
    assign levelOut        = r_level;
    assign overflowOut     = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_sync_stream_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module  : tb_sync_stream_fifo
//  Brief   : Self-checking bench running a LOW_LAT=1 and a LOW_LAT=0 instance
//            side by side against a queue-based reference model.
//  Rev     : 1.0
// ============================================================================
module tb_sync_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wrEn;
    logic          rdRdy;
    logic          clr;
    logic [DW-1:0] wrData;

    logic          full  [2];
    logic          af    [2];
    logic          valid [2];
    logic          ovf   [2];
    logic [DW-1:0] dat   [2];
    logic [LW-1:0] lvl   [2];

    always #2 clk = ~clk;

    sync_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LOW_LAT(1'b1), .AF_THRESH(AF)) u_dut_ll (
        .clkIn(clk), .rstIn(rst), .wrEnIn(wrEn), .wrDataIn(wrData),
        .wrFullOut(full[0]), .wrAlmostFullOut(af[0]), .rdReadyIn(rdRdy),
        .rdDataOut(dat[0]), .rdDataValidOut(valid[0]), .levelOut(lvl[0]),
        .overflowOut(ovf[0]), .overflowClrIn(clr)
    );

    sync_stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LOW_LAT(1'b0), .AF_THRESH(AF)) u_dut_reg (
        .clkIn(clk), .rstIn(rst), .wrEnIn(wrEn), .wrDataIn(wrData),
        .wrFullOut(full[1]), .wrAlmostFullOut(af[1]), .rdReadyIn(rdRdy),
        .rdDataOut(dat[1]), .rdDataValidOut(valid[1]), .levelOut(lvl[1]),
        .overflowOut(ovf[1]), .overflowClrIn(clr)
    );

    // Reference model: each accepted word with the cycle it was accepted in.
    // A word may be shown one cycle after acceptance (low latency) or must
    // wait at least two cycles (registered path).
    typedef struct {
        logic [DW-1:0] d;
        int unsigned   c;
    } ent_t;

    ent_t        mq [2][$];
    bit          mv   [2];
    bit          movf [2];
    int unsigned mcyc;
    int          total;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            mv[i]   = 1'b0;
            movf[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit mfull;
            bit pop;
            mfull = (mq[i].size() == DEPTH);
            pop   = mv[i] && rdRdy;
            if (pop) void'(mq[i].pop_front());
            if (wrEn && !mfull) mq[i].push_back('{d: wrData, c: mcyc});
            if (wrEn && mfull) movf[i] = 1'b1;
            else if (clr)      movf[i] = 1'b0;
            if (mq[i].size() == 0) mv[i] = 1'b0;
            else                   mv[i] = (i == 0) || (mq[i][0].c != mcyc);
        end
        mcyc++;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            int n;
            n = mq[i].size();
            chk($sformatf("level%0d", i), 32'(lvl[i]), 32'(n));
            chk($sformatf("full%0d", i), 32'(full[i]), 32'(n == DEPTH));
            chk($sformatf("afull%0d", i), 32'(af[i]), 32'(n >= AF));
            chk($sformatf("ovf%0d", i), 32'(ovf[i]), 32'(movf[i]));
            chk($sformatf("valid%0d", i), 32'(valid[i]), 32'(mv[i]));
            if (mv[i]) chk($sformatf("data%0d", i), 32'(dat[i]), 32'(mq[i][0].d));
        end
    endtask

    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        wrEn   = w;
        wrData = d;
        rdRdy  = r;
        clr    = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_lvl%0d", tag, i), 32'(lvl[i]), 32'd0);
            chk($sformatf("%s_val%0d", tag, i), 32'(valid[i]), 32'd0);
            chk($sformatf("%s_dat%0d", tag, i), 32'(dat[i]), 32'd0);
            chk($sformatf("%s_full%0d", tag, i), 32'(full[i]), 32'd0);
            chk($sformatf("%s_af%0d", tag, i), 32'(af[i]), 32'd0);
            chk($sformatf("%s_ovf%0d", tag, i), 32'(ovf[i]), 32'd0);
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        mcyc   = 0;
        rst    = 1'b1;
        wrEn   = 1'b0;
        rdRdy  = 1'b0;
        clr    = 1'b0;
        wrData = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check_all();

        // Reset mid-stream at level 5, then a single write into the empty FIFO.
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0, 1'b0);
        chk("t1_lvl5_ll", 32'(lvl[0]), 32'd5);
        chk("t1_lvl5_reg", 32'(lvl[1]), 32'd5);
        wrEn = 1'b0;
        rst  = 1'b1;
        #1;
        check_zero("t1_rst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("t1_n1_val_ll", 32'(valid[0]), 32'd1);
        chk("t1_n1_dat_ll", 32'(dat[0]), 32'hA5);
        chk("t1_n1_val_reg", 32'(valid[1]), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("t1_n2_val_reg", 32'(valid[1]), 32'd1);
        chk("t1_n2_dat_reg", 32'(dat[1]), 32'hA5);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to full with no reader, then overflow.
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, 8'(k), 1'b0, 1'b0);
            chk("t2_af", 32'(af[0]), 32'(k + 1 >= 14));
            chk("t2_full", 32'(full[1]), 32'(k + 1 == 16));
        end
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t2_ovf", 32'(ovf[0]), 32'd1);
        chk("t2_lvl", 32'(lvl[1]), 32'd16);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("t4_clr", 32'(ovf[1]), 32'd0);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("t3_lvl", 32'(lvl[0]), 32'd15);
        chk("t3_ovf", 32'(ovf[1]), 32'd1);
        chk("t3_head", 32'(dat[0]), 32'h01);
        cyc(1'b1, 8'h10, 1'b0, 1'b0);
        cyc(1'b1, 8'h66, 1'b0, 1'b1);
        chk("t4_setwins", 32'(ovf[0]), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            chk("t2_drain_ll", 32'(dat[0]), 32'(k));
            chk("t2_drain_reg", 32'(dat[1]), 32'(k));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("t2_empty", 32'(lvl[0]), 32'd0);

        // Streaming through the bypass with the consumer always ready.
        for (int k = 1; k <= 64; k++) begin
            cyc(1'b1, 8'(k), 1'b1, 1'b0);
            chk("t5_val", 32'(valid[0]), 32'd1);
            chk("t5_dat", 32'(dat[0]), 32'(k));
            chk("t5_lvl", 32'(lvl[0] <= 1), 32'd1);
        end
        repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            cyc(($urandom % 2) == 0, 8'($urandom), ($urandom % 10) < 3, ($urandom % 64) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
